// File: rtl/remote_key_ctrl.sv
// remote_key_ctrl: debounced key events (press/repeat/release) from remote_rcv
// strobes, queued in a small FIFO and delivered over a valid/ready handshake.
//
// Optional build macro: REMOTE_KEY_AUTOREPEAT_EN
//   defined   : REPEAT events start at the HOLD_CNT-th repeat code and are then
//               emitted once per RATE_DIV repeat codes.
//   undefined : every repeat code while a key is held emits a REPEAT event.
//
// Ports:
//   sys_clk, sys_rst_n      clock, async active-low reset
//   data_en, repeat_en      one-cycle strobes from remote_rcv
//   data[7:0]               key code, valid with data_en
//   evt_valid, evt_ready    event handshake (FIFO head)
//   evt_type[1:0]           0 PRESS, 1 REPEAT, 2 RELEASE
//   evt_code[7:0]           key code of the head event
//   key_held                a key is currently pressed
//   overflow                pulse: an event was dropped (FIFO full)

module remote_key_ctrl #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int RELEASE_MS = 150,
   parameter int HOLD_CNT   = 3,
   parameter int RATE_DIV   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       data_en,
   input  logic       repeat_en,
   input  logic [7:0] data,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [1:0] evt_type,
   output logic [7:0] evt_code,
   output logic       key_held,
   output logic       overflow
);

   localparam int RELEASE_CYC = CLK_FREQ / 1000 * RELEASE_MS;
   localparam int TW =
      (RELEASE_CYC > 2) ? $clog2(RELEASE_CYC) : 1;
   localparam int RW =
      (HOLD_CNT > 0) ? $clog2(HOLD_CNT + 1) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [TW-1:0] TMR_LAST = TW'(RELEASE_CYC - 1);
   localparam logic [RW-1:0] REP_SAT  = RW'(HOLD_CNT);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HELD = 2'd1;
   localparam logic [1:0] PEND = 2'd2;

   localparam logic [1:0] EVT_PRESS   = 2'd0;
   localparam logic [1:0] EVT_REPEAT  = 2'd1;
   localparam logic [1:0] EVT_RELEASE = 2'd2;

   // Parameter sanity, caught at elaboration.
   generate
      if (RATE_DIV < 1) begin : g_bad_rate
         $error("RATE_DIV must be >= 1");
      end
      if (FIFO_DEPTH < 2 ||
          (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   // ---------------------------------------------------------------
   // Key FSM
   // ---------------------------------------------------------------
   logic [1:0]    state, state_n;
   logic [7:0]    code_r, code_n;
   logic [7:0]    new_r, new_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [RW-1:0] rep_cnt, rep_n;

   logic          req;
   logic [1:0]    req_type;
   logic [7:0]    req_code;

`ifdef REMOTE_KEY_AUTOREPEAT_EN
   localparam int DW =
      (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(RATE_DIV - 1);

   logic [DW-1:0] div_cnt, div_n;
   logic          at_hold;

   // k = rep_cnt + 1 is the index of the repeat code being handled.
   assign at_hold = (int'(rep_cnt) + 1) >= HOLD_CNT;
`endif

   always_comb begin
      state_n  = state;
      code_n   = code_r;
      new_n    = new_r;
      tmr_n    = tmr;
      rep_n    = rep_cnt;
`ifdef REMOTE_KEY_AUTOREPEAT_EN
      div_n    = div_cnt;
`endif
      req      = 1'b0;
      req_type = EVT_PRESS;
      req_code = code_r;

      unique case (1'b1)
         (state == IDLE): begin
            if (data_en) begin
               req      = 1'b1;
               req_type = EVT_PRESS;
               req_code = data;
               code_n   = data;
               tmr_n    = '0;
               rep_n    = '0;
`ifdef REMOTE_KEY_AUTOREPEAT_EN
               div_n    = '0;
`endif
               state_n  = HELD;
            end
         end
         (state == HELD): begin
            tmr_n = tmr + 1'b1;
            if (data_en) begin
               // Any new frame ends the current key first.
               req      = 1'b1;
               req_type = EVT_RELEASE;
               new_n    = data;
               state_n  = PEND;
            end else if (repeat_en) begin
               tmr_n    = '0;
               req_type = EVT_REPEAT;
               if (rep_cnt != REP_SAT) begin
                  rep_n = rep_cnt + 1'b1;
               end
`ifdef REMOTE_KEY_AUTOREPEAT_EN
               if (at_hold) begin
                  req   = (div_cnt == '0);
                  div_n = (div_cnt == DIV_LAST) ?
                          '0 : div_cnt + 1'b1;
               end
`else
               req      = 1'b1;
`endif
            end else if (tmr == TMR_LAST) begin
               req      = 1'b1;
               req_type = EVT_RELEASE;
               state_n  = IDLE;
            end
         end
         (state == PEND): begin
            req      = 1'b1;
            req_type = EVT_PRESS;
            req_code = new_r;
            code_n   = new_r;
            tmr_n    = '0;
            rep_n    = '0;
`ifdef REMOTE_KEY_AUTOREPEAT_EN
            div_n    = '0;
`endif
            state_n  = HELD;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         code_r  <= '0;
         new_r   <= '0;
         tmr     <= '0;
         rep_cnt <= '0;
      end else begin
         state   <= state_n;
         code_r  <= code_n;
         new_r   <= new_n;
         tmr     <= tmr_n;
         rep_cnt <= rep_n;
      end
   end

`ifdef REMOTE_KEY_AUTOREPEAT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_n;
      end
   end
`endif

   assign key_held = (state != IDLE);

   // ---------------------------------------------------------------
   // Registered push request
   // ---------------------------------------------------------------
   logic       push_r;
   logic [1:0] push_type;
   logic [7:0] push_code;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         push_r    <= 1'b0;
         push_type <= '0;
         push_code <= '0;
      end else begin
         push_r    <= req;
         push_type <= req_type;
         push_code <= req_code;
      end
   end

   // ---------------------------------------------------------------
   // Event FIFO
   // ---------------------------------------------------------------
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic          full;
   logic          pop;
   logic          wr;
   logic [9:0]    head;

   assign full = (cnt == FULL_CNT);
   assign pop  = evt_valid & evt_ready;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign wr   = push_r & (~full | pop);

   always_ff @(posedge sys_clk) begin
      if (wr) begin
         mem[wptr] <= {push_type, push_code};
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         cnt      <= cnt + CW'(wr) - CW'(pop);
         overflow <= push_r & full & ~pop;
      end
   end

   // Head is masked so the outputs read zero whenever the FIFO is
   // empty, including straight out of (asynchronous) reset.
   assign head      = mem[rptr];
   assign evt_valid = (cnt != '0);
   assign evt_type  = evt_valid ? head[9:8] : 2'd0;
   assign evt_code  = evt_valid ? head[7:0] : 8'd0;

endmodule

// File: tb/tb_remote_key_ctrl.sv
// tb_remote_key_ctrl: directed + randomized bench for remote_key_ctrl,
// checked every cycle against an event-level reference model.

module tb_remote_key_ctrl;

   localparam int CLK_FREQ   = 50_000;
   localparam int RELEASE_MS = 2;
   localparam int HOLD       = 3;
   localparam int RATE       = 2;
   localparam int DEPTH      = 4;
   localparam int RC         = CLK_FREQ / 1000 * RELEASE_MS;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       data_en;
   logic       repeat_en;
   logic [7:0] data;
   logic       evt_valid;
   logic       evt_ready;
   logic [1:0] evt_type;
   logic [7:0] evt_code;
   logic       key_held;
   logic       overflow;

   remote_key_ctrl #(
      .CLK_FREQ  (CLK_FREQ),
      .RELEASE_MS(RELEASE_MS),
      .HOLD_CNT  (HOLD),
      .RATE_DIV  (RATE),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .data_en  (data_en),
      .repeat_en(repeat_en),
      .data     (data),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_type (evt_type),
      .evt_code (evt_code),
      .key_held (key_held),
      .overflow (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int rep_seen;
   int ovf_seen;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Key status plus the queue of events sitting in the FIFO.
   int       e;
   bit       m_held, m_pend;
   bit [7:0] m_key, m_pcode;
   int       m_last, m_k;
   bit       req_v;
   bit [9:0] req_e;
   bit [9:0] q[$];
   bit       m_ovf;

   function automatic bit emits_repeat(input int k);
`ifdef REMOTE_KEY_AUTOREPEAT_EN
      return (k >= HOLD) && ((k - HOLD) % RATE == 0);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      e = 0; m_held = 0; m_pend = 0; m_key = 0; m_pcode = 0;
      m_last = 0; m_k = 0; req_v = 0; req_e = 0; m_ovf = 0;
      q.delete();
   endtask

   task automatic model_edge(input bit de, input bit re,
                             input bit [7:0] d, input bit rdy);
      bit       nv;
      bit [9:0] ne;
      e++;
      m_ovf = 0;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (req_v) begin
         if (q.size() < DEPTH) q.push_back(req_e);
         else m_ovf = 1;
      end
      nv = 0;
      ne = 0;
      if (m_pend) begin
         nv = 1; ne = {2'd0, m_pcode};
         m_key = m_pcode; m_last = e; m_k = 0; m_pend = 0;
      end else if (m_held) begin
         if (de) begin
            nv = 1; ne = {2'd2, m_key};
            m_pend = 1; m_pcode = d;
         end else if (re) begin
            m_last = e; m_k++;
            nv = emits_repeat(m_k); ne = {2'd1, m_key};
         end else if (e - m_last == RC) begin
            nv = 1; ne = {2'd2, m_key}; m_held = 0;
         end
      end else if (de) begin
         nv = 1; ne = {2'd0, d};
         m_held = 1; m_key = d; m_last = e; m_k = 0;
      end
      req_v = nv;
      req_e = ne;
   endtask

   task automatic check_outputs();
      chk("evt_valid", 32'(evt_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         chk("evt_type", 32'(evt_type), 32'(q[0][9:8]));
         chk("evt_code", 32'(evt_code), 32'(q[0][7:0]));
      end
      chk("key_held", 32'(key_held), 32'(m_held));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (overflow) ovf_seen++;
   endtask

   task automatic cyc(input bit de, input bit re,
                      input logic [7:0] d, input bit rdy);
      data_en   = de;
      repeat_en = re;
      data      = d;
      evt_ready = rdy;
      if (evt_valid && rdy && evt_type == 2'd1) rep_seen++;
      @(posedge sys_clk);
      model_edge(de, re, d, rdy);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, rdy);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
      chk({tag, "_type"},  32'(evt_type),  32'd0);
      chk({tag, "_code"},  32'(evt_code),  32'd0);
      chk({tag, "_held"},  32'(key_held),  32'd0);
      chk({tag, "_ovf"},   32'(overflow),  32'd0);
   endtask

   initial begin
      int pde, pre, prdy;
      sys_rst_n = 1'b0;
      data_en   = 1'b0;
      repeat_en = 1'b0;
      data      = 8'h00;
      evt_ready = 1'b1;
      model_reset();
      #2;
      check_zero("rst");
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;

      // single press, release by timeout
      cyc(1'b1, 1'b0, 8'h45, 1'b1);
      idle(RC + 10, 1'b1);

      // hold with repeat codes every 60 cycles
      cyc(1'b1, 1'b0, 8'h16, 1'b1);
      rep_seen = 0;
      for (int i = 0; i < 7; i++) begin
         idle(59, 1'b1);
         cyc(1'b0, 1'b1, 8'h00, 1'b1);
      end
      idle(RC + 10, 1'b1);
`ifdef REMOTE_KEY_AUTOREPEAT_EN
      chk("hold_repeats", 32'(rep_seen), 32'd3);
`else
      chk("hold_repeats", 32'(rep_seen), 32'd7);
`endif

      // key change
      cyc(1'b1, 1'b0, 8'h0C, 1'b1);
      idle(29, 1'b1);
      cyc(1'b1, 1'b0, 8'h18, 1'b1);
      idle(RC + 10, 1'b1);

      // orphan repeat, then collision in IDLE
      cyc(1'b0, 1'b1, 8'h00, 1'b1);
      idle(5, 1'b1);
      cyc(1'b1, 1'b1, 8'h22, 1'b1);
      idle(RC + 10, 1'b1);

      // backpressure: 5 events into a 4-deep FIFO
      ovf_seen = 0;
      cyc(1'b1, 1'b0, 8'hA1, 1'b0);
      idle(10, 1'b0);
      cyc(1'b1, 1'b0, 8'hA2, 1'b0);
      idle(10, 1'b0);
      cyc(1'b1, 1'b0, 8'hA3, 1'b0);
      idle(10, 1'b0);
      chk("bp_overflows", 32'(ovf_seen), 32'd1);
      idle(RC + 10, 1'b1);

      // reset mid-hold with events queued
      cyc(1'b1, 1'b0, 8'h33, 1'b0);
      idle(10, 1'b0);
      cyc(1'b1, 1'b0, 8'h44, 1'b0);
      idle(3, 1'b0);
      sys_rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      repeat (2) @(posedge sys_clk);
      model_reset();
      #1;
      sys_rst_n = 1'b1;
      idle(RC + 20, 1'b1);

      // randomized phases with different strobe densities
      for (int ph = 0; ph < 4; ph++) begin
         pde  = 2 + ph;
         pre  = 2 + 2 * ph;
         prdy = (ph == 2) ? 50 : 90;
         for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) < pde,
                $urandom_range(0, 99) < pre,
                8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < prdy);
         end
      end
      idle(RC + 10, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
